// File: rtl/prf_sched_pkg.sv
// Shared types and helper constants for the PRF write-port scheduler.
package prf_sched_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam int unsigned NUM_REQ_DEF    = 8;
  localparam int unsigned NUM_WR_DEF     = 6;
  localparam int unsigned SRAM_DEPTH_DEF = 16;
  localparam int unsigned INIT_BASE_DEF  = 0;

  // Number of sweep cycles needed to clear [base, depth) with nwr ports.
  function automatic int unsigned init_cycles(int unsigned depth, int unsigned base,
                                              int unsigned nwr);
    return (depth - base + nwr - 1) / nwr;
  endfunction

  // $clog2 clamped to at least one bit so single-entry vectors stay legal.
  function automatic int unsigned clog2_min1(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned INIT_CYCLES = init_cycles(SRAM_DEPTH_DEF, INIT_BASE_DEF, NUM_WR_DEF);
  localparam int unsigned RR_W        = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/prf_sched_picker.sv
// Rotating-priority multi-grant picker; suppresses duplicate addresses within a cycle.
module prf_sched_picker #(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned NUM_WR     = 6,
  parameter int unsigned SRAM_INDEX = 4,
  parameter int unsigned RR_W       = 3,
  parameter int unsigned PORT_W     = 3
) (
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0] addr_i,
  input  logic [RR_W-1:0]               rr_ptr_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [NUM_REQ*PORT_W-1:0]     port_idx_o,
  output logic [RR_W-1:0]               next_rr_o
);

  logic [NUM_WR*SRAM_INDEX-1:0] taken;
  logic [SRAM_INDEX-1:0]        cur_addr;
  logic                         conflict;
  int unsigned                  cnt;
  int unsigned                  r;

  // Scan from rr_ptr, grant valid non-conflicting requesters to ports in order.
  always_comb begin
    grant_o    = '0;
    port_idx_o = '0;
    next_rr_o  = rr_ptr_i;
    taken      = '0;
    cur_addr   = '0;
    conflict   = 1'b0;
    cnt        = 0;
    r          = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      r        = (32'(rr_ptr_i) + i) % NUM_REQ;
      cur_addr = addr_i[r*SRAM_INDEX +: SRAM_INDEX];
      conflict = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (j < cnt && taken[j*SRAM_INDEX +: SRAM_INDEX] == cur_addr) conflict = 1'b1;
      end
      if (valid_i[RR_W'(r)] && cnt < NUM_WR && !conflict) begin
        grant_o[RR_W'(r)]                  = 1'b1;
        port_idx_o[r*PORT_W +: PORT_W]     = PORT_W'(cnt);
        taken[cnt*SRAM_INDEX +: SRAM_INDEX] = cur_addr;
        cnt                                = cnt + 1;
        next_rr_o                          = RR_W'((r + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/prf_write_scheduler.sv
// PRF write-port scheduler: post-reset zero sweep, then rotating-priority writeback grants.
module prf_write_scheduler
  import prf_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 8,
  parameter int unsigned NUM_WR     = 6,
  parameter int unsigned SRAM_DEPTH = 16,
  parameter int unsigned SRAM_INDEX = 4,
  parameter int unsigned SRAM_WIDTH = 32,
  parameter int unsigned INIT_BASE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*SRAM_INDEX-1:0] req_addr_i,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_WR-1:0]             wr_en_o,
  output logic [NUM_WR*SRAM_INDEX-1:0]  wr_addr_o,
  output logic [NUM_WR*SRAM_WIDTH-1:0]  wr_data_o,
  output logic                          busy_o
);

  localparam int unsigned RRW    = clog2_min1(NUM_REQ);
  localparam int unsigned PORT_W = clog2_min1(NUM_WR);
  localparam int unsigned PTR_W  = $clog2(SRAM_DEPTH + NUM_WR + 1);

  sched_state_e               state;
  logic [PTR_W-1:0]           init_ptr;
  logic [RRW-1:0]             rr_ptr;
  logic [RRW-1:0]             next_rr;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ*PORT_W-1:0]  port_idx;
  logic [NUM_WR-1:0]          en_c;
  logic [NUM_WR*SRAM_INDEX-1:0] addr_c;
  logic [NUM_WR*SRAM_WIDTH-1:0] data_c;
  int unsigned                ptr_u;
  int unsigned                k;

  assign ptr_u = 32'(init_ptr);

  prf_sched_picker #(
    .NUM_REQ    (NUM_REQ),
    .NUM_WR     (NUM_WR),
    .SRAM_INDEX (SRAM_INDEX),
    .RR_W       (RRW),
    .PORT_W     (PORT_W)
  ) u_picker (
    .valid_i    (req_valid_i),
    .addr_i     (req_addr_i),
    .rr_ptr_i   (rr_ptr),
    .grant_o    (grant),
    .port_idx_o (port_idx),
    .next_rr_o  (next_rr)
  );

  // Handshakes only complete once the sweep is done.
  assign req_ready_o = (state == RUN) ? grant : '0;

  // Next port contents: sweep slots during INIT, granted requests during RUN.
  always_comb begin
    en_c   = '0;
    addr_c = '0;
    data_c = '0;
    k      = 0;
    if (state == INIT) begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (ptr_u + p < SRAM_DEPTH) begin
          en_c[PORT_W'(p)]                  = 1'b1;
          addr_c[p*SRAM_INDEX +: SRAM_INDEX] = SRAM_INDEX'(ptr_u + p);
        end
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (grant[RRW'(r)]) begin
          k                                  = 32'(port_idx[r*PORT_W +: PORT_W]);
          en_c[PORT_W'(k)]                   = 1'b1;
          addr_c[k*SRAM_INDEX +: SRAM_INDEX] = req_addr_i[r*SRAM_INDEX +: SRAM_INDEX];
          data_c[k*SRAM_WIDTH +: SRAM_WIDTH] = req_data_i[r*SRAM_WIDTH +: SRAM_WIDTH];
        end
      end
    end
  end

  // State, sweep pointer, rotating pointer and registered write ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_ptr  <= PTR_W'(INIT_BASE);
      rr_ptr    <= '0;
      wr_en_o   <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      busy_o    <= 1'b1;
    end else begin
      wr_en_o   <= en_c;
      wr_addr_o <= addr_c;
      wr_data_o <= data_c;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + PTR_W'(NUM_WR);
          if (ptr_u + NUM_WR >= SRAM_DEPTH) begin
            state  <= RUN;
            busy_o <= 1'b0;
          end
        end
        RUN: rr_ptr <= next_rr;
      endcase
    end
  end

endmodule

// File: tb/tb_prf_write_scheduler.sv
// Directed bench for prf_write_scheduler with a behavioural SRAM behind the write ports.
module tb_prf_write_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req_valid;
  logic [31:0]  req_addr;
  logic [255:0] req_data;
  logic [7:0]   req_ready;
  logic [5:0]   wr_en;
  logic [23:0]  wr_addr;
  logic [191:0] wr_data;
  logic         busy;

  logic [7:0]   req_valid2;
  logic [31:0]  req_addr2;
  logic [255:0] req_data2;
  logic [7:0]   req_ready2;
  logic [5:0]   wr_en2;
  logic [23:0]  wr_addr2;
  logic [191:0] wr_data2;
  logic         busy2;

  logic [31:0]  mem  [16];
  logic [31:0]  mem2 [16];
  logic         preload;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prf_write_scheduler dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(req_ready), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );

  prf_write_scheduler #(.INIT_BASE(10)) dut2 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid2), .req_addr_i(req_addr2),
    .req_data_i(req_data2), .req_ready_o(req_ready2), .wr_en_o(wr_en2),
    .wr_addr_o(wr_addr2), .wr_data_o(wr_data2), .busy_o(busy2)
  );

  // Behavioural SRAMs: commit the presented writes at the end of the cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= 32'h0;
        mem2[i] <= 32'hA500_0000 + 32'(i);
      end
    end else begin
      for (int p = 0; p < 6; p++) begin
        if (wr_en[p])  mem[wr_addr[p*4 +: 4]]   <= wr_data[p*32 +: 32];
        if (wr_en2[p]) mem2[wr_addr2[p*4 +: 4]] <= wr_data2[p*32 +: 32];
      end
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] a, input logic [31:0] d);
    req_addr[r*4 +: 4]   = a;
    req_data[r*32 +: 32] = d;
  endtask

  initial begin
    reset      = 1'b1;
    preload    = 1'b1;
    req_valid  = 8'hFF;
    req_valid2 = 8'h00;
    req_addr2  = '0;
    req_data2  = '0;
    for (int r = 0; r < 8; r++) set_req(r, 4'(r + 1), 32'h100 + 32'(r));

    // Reset values
    tick();
    chk("rst_en",    192'(wr_en),   192'h0);
    chk("rst_addr",  192'(wr_addr), 192'h0);
    chk("rst_data",  wr_data,       192'h0);
    chk("rst_busy",  192'(busy),    192'h1);
    chk("rst_ready", 192'(req_ready), 192'h0);
    chk("rst_busy2", 192'(busy2),   192'h1);
    tick();
    reset   = 1'b0;
    preload = 1'b0;

    // Init sweep, default base: 0-5, 6-11, 12-15
    tick();
    chk("init1_en",    192'(wr_en),   192'h3F);
    chk("init1_addr",  192'(wr_addr), 192'h543210);
    chk("init1_data",  wr_data,       192'h0);
    chk("init1_busy",  192'(busy),    192'h1);
    chk("init1_ready", 192'(req_ready), 192'h0);
    chk("b10_en",      192'(wr_en2),   192'h3F);
    chk("b10_addr",    192'(wr_addr2), 192'hFEDCBA);
    chk("b10_busy",    192'(busy2),    192'h0);
    tick();
    chk("init2_en",    192'(wr_en),   192'h3F);
    chk("init2_addr",  192'(wr_addr), 192'hBA9876);
    chk("init2_busy",  192'(busy),    192'h1);
    chk("init2_ready", 192'(req_ready), 192'h0);
    chk("b10_idle_en", 192'(wr_en2),  192'h0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("b10_mem%0d", i), 192'(mem2[i]), (i < 10) ? 192'(32'hA500_0000 + 32'(i)) : 192'h0);
    tick();
    chk("init3_en",   192'(wr_en),   192'h0F);
    chk("init3_addr", 192'(wr_addr), 192'h00FEDC);
    chk("init3_busy", 192'(busy),    192'h0);
    chk("run_ready0", 192'(req_ready), 192'h3F);

    // All eight valid, rr_ptr=0: requesters 0-5 on ports 0-5
    tick();
    chk("all_en",   192'(wr_en),   192'h3F);
    chk("all_addr", 192'(wr_addr), 192'h654321);
    chk("all_data", wr_data, {32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
    req_valid = 8'hCF;
    for (int r = 0; r < 4; r++) set_req(r, 4'(r + 1), 32'h200 + 32'(r));
    #1;
    chk("rot_ready", 192'(req_ready), 192'hCF);

    // rr_ptr=6: order 6,7,0,1,2,3
    tick();
    chk("rot_en",   192'(wr_en),   192'h3F);
    chk("rot_addr", 192'(wr_addr), 192'h432187);
    chk("rot_data", wr_data, {32'h203, 32'h202, 32'h201, 32'h200, 32'h107, 32'h106});
    req_valid = 8'h80;
    #1;
    chk("r7_ready", 192'(req_ready), 192'h80);
    tick();
    chk("r7_en",   192'(wr_en),   192'h01);
    chk("r7_addr", 192'(wr_addr), 192'h000008);

    // rr_ptr=0: requesters 2 and 5 both target address 9
    req_valid = 8'h24;
    set_req(2, 4'd9, 32'hAAAA_0002);
    set_req(5, 4'd9, 32'h5555_0005);
    #1;
    chk("dup_ready1", 192'(req_ready), 192'h04);
    tick();
    chk("dup_en1",   192'(wr_en),   192'h01);
    chk("dup_addr1", 192'(wr_addr), 192'h000009);
    chk("dup_data1", 192'(wr_data[31:0]), 192'hAAAA_0002);
    req_valid = 8'h20;
    #1;
    chk("dup_ready2", 192'(req_ready), 192'h20);
    tick();
    chk("dup_en2",   192'(wr_en),   192'h01);
    chk("dup_addr2", 192'(wr_addr), 192'h000009);
    chk("dup_data2", 192'(wr_data[31:0]), 192'h5555_0005);
    req_valid = 8'h00;
    #1;
    chk("idle_ready", 192'(req_ready), 192'h0);
    tick();
    chk("idle_en",  192'(wr_en),  192'h0);
    chk("dup_mem9", 192'(mem[9]), 192'h5555_0005);

    // Single requester 3 writes 0xDEADBEEF to address 7
    req_valid = 8'h08;
    set_req(3, 4'd7, 32'hDEAD_BEEF);
    #1;
    chk("one_ready", 192'(req_ready), 192'h08);
    tick();
    chk("one_en",   192'(wr_en),   192'h01);
    chk("one_addr", 192'(wr_addr), 192'h000007);
    chk("one_data", 192'(wr_data[31:0]), 192'hDEAD_BEEF);
    req_valid = 8'h00;
    tick();
    chk("one_mem7", 192'(mem[7]), 192'hDEAD_BEEF);
    chk("mem1_kept", 192'(mem[1]), 192'h200);

    // Reset mid-traffic with rr_ptr=4
    for (int r = 0; r < 8; r++) set_req(r, 4'(r + 1), 32'h300 + 32'(r));
    req_valid = 8'hFF;
    #1;
    chk("pre_rst_ready", 192'(req_ready), 192'hF3);
    reset = 1'b1;
    tick();
    chk("mid_rst_en",    192'(wr_en),     192'h0);
    chk("mid_rst_busy",  192'(busy),      192'h1);
    chk("mid_rst_ready", 192'(req_ready), 192'h0);
    reset = 1'b0;
    tick();
    chk("re_init_en",   192'(wr_en),   192'h3F);
    chk("re_init_addr", 192'(wr_addr), 192'h543210);
    chk("re_init_data", wr_data,       192'h0);
    chk("re_init_ready", 192'(req_ready), 192'h0);
    chk("re_b10_addr",  192'(wr_addr2), 192'hFEDCBA);
    tick();
    chk("re_init2_busy", 192'(busy), 192'h1);
    tick();
    chk("re_run_busy",  192'(busy),      192'h0);
    chk("re_run_ready", 192'(req_ready), 192'h3F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
